cska_pipe: RTL and testbench

Pipelined, parametrised carry-skip adder/subtractor. It is the successor of the combinational cska_top. It accepts one N-bit operation per cycle over a valid/ready handshake and resolves one BLOCK_SIZE-bit block per pipeline stage, using carry-skip bypass inside each block. Results leave through a backpressured valid/ready output together with carry, signed overflow and per-block skip flags. It sits between operand-issue logic and any consumer that needs wide sums at full clock rate.

---
 rtl/cska_pipe.sv | 142 ++++++++++++++
 tb/tb_cska_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cska_pipe.sv
// Pipelined carry-skip adder/subtractor: one BLOCK_SIZE-bit block resolved per stage,
// full-rate valid/ready flow with a pipe-wide stall on output backpressure.
module cska_pipe #(
  parameter int N          = 16,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               A,
  input  logic [N-1:0]               B,
  input  logic                       Cin,
  input  logic                       Sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               Sum,
  output logic                       Cout,
  output logic                       Ovf,
  output logic [N/BLOCK_SIZE-1:0]    Skip
);

  localparam int NB = N / BLOCK_SIZE;

  generate
    if (N <= 0 || BLOCK_SIZE <= 0 || (N % BLOCK_SIZE) != 0) begin : g_param_check
      $error("cska_pipe: N must be a positive multiple of BLOCK_SIZE");
    end
  endgenerate

  typedef struct packed {
    logic                  skip;
    logic                  cmsb;
    logic                  co;
    logic [BLOCK_SIZE-1:0] s;
  } blk_t;

  // Ripple through one block; carry-out bypasses the ripple when every propagate bit is set.
  function automatic blk_t blk_add(input logic [BLOCK_SIZE-1:0] a,
                                   input logic [BLOCK_SIZE-1:0] b,
                                   input logic                  ci);
    blk_t                  r;
    logic [BLOCK_SIZE-1:0] p;
    logic [BLOCK_SIZE-1:0] g;
    logic                  c;
    p = a ^ b;
    g = a & b;
    c = ci;
    r = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      r.s[i] = p[i] ^ c;
      r.cmsb = c;
      c      = g[i] | (p[i] & c);
    end
    r.skip = &p;
    r.co   = r.skip ? ci : c;
    return r;
  endfunction

  logic          adv;
  logic [NB-1:0] vld_q;
  logic [NB-1:0] vld_d;

  logic [N-1:0]  a_q    [NB];
  logic [N-1:0]  b_q    [NB];
  logic [N-1:0]  sum_q  [NB];
  logic          c_q    [NB];
  logic [NB-1:0] skip_q [NB];
  logic          ovf_q;

  logic [N-1:0]  a_in    [NB];
  logic [N-1:0]  b_in    [NB];
  logic [N-1:0]  sum_in  [NB];
  logic          c_in    [NB];
  logic [NB-1:0] skip_in [NB];

  logic [N-1:0]  sum_d  [NB];
  logic          c_d    [NB];
  logic [NB-1:0] skip_d [NB];
  logic          ovf_d;
  blk_t          blk    [NB];

  assign adv       = !vld_q[NB-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[NB-1];

  // Stage inputs: stage 0 takes the effective operands, later stages take the skew registers.
  always_comb begin
    a_in[0]    = A;
    b_in[0]    = Sub ? ~B : B;
    c_in[0]    = Sub ? ~Cin : Cin;
    sum_in[0]  = '0;
    skip_in[0] = '0;
    vld_d[0]   = in_valid;
    for (int k = 1; k < NB; k++) begin
      a_in[k]    = a_q[k-1];
      b_in[k]    = b_q[k-1];
      c_in[k]    = c_q[k-1];
      sum_in[k]  = sum_q[k-1];
      skip_in[k] = skip_q[k-1];
      vld_d[k]   = vld_q[k-1];
    end
    for (int k = 0; k < NB; k++) begin
      blk[k] = blk_add(a_in[k][k*BLOCK_SIZE +: BLOCK_SIZE],
                       b_in[k][k*BLOCK_SIZE +: BLOCK_SIZE], c_in[k]);
      sum_d[k] = sum_in[k];
      sum_d[k][k*BLOCK_SIZE +: BLOCK_SIZE] = blk[k].s;
      skip_d[k]    = skip_in[k];
      skip_d[k][k] = blk[k].skip;
      c_d[k]       = blk[k].co;
    end
    ovf_d = blk[NB-1].cmsb ^ blk[NB-1].co;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
    end
  end

  // Data registers carry no reset; the outputs are qualified by the valid bit instead.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < NB; k++) begin
        a_q[k]    <= a_in[k];
        b_q[k]    <= b_in[k];
        sum_q[k]  <= sum_d[k];
        c_q[k]    <= c_d[k];
        skip_q[k] <= skip_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign Sum  = out_valid ? sum_q[NB-1]  : '0;
  assign Cout = out_valid & c_q[NB-1];
  assign Ovf  = out_valid & ovf_q;
  assign Skip = out_valid ? skip_q[NB-1] : '0;

endmodule

// File: tb/tb_cska_pipe.sv
// Bench for cska_pipe: vector table plus hand sequences, checked through an acceptance-order scoreboard.
module tb_cska_pipe;
  localparam int N   = 16;
  localparam int BS  = 4;
  localparam int NB  = N / BS;
  localparam int LAT = NB;
  localparam int NV  = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic          Cin;
  logic          Sub;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  Sum;
  logic          Cout;
  logic          Ovf;
  logic [NB-1:0] Skip;

  always #5 clk = ~clk;

  cska_pipe #(.N(N), .BLOCK_SIZE(BS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout), .Ovf(Ovf), .Skip(Skip)
  );

  typedef struct {
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          cin;
    logic          sub;
    logic [N-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic [NB-1:0] skip;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
    bit   chk_lat;
  } exp_t;

  exp_t sb[$];
  vec_t cur;
  vec_t tbl[NV];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   first_seen = -1;
  bit   lat_chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                              input logic sub, input logic [N-1:0] sum, input logic cout,
                              input logic ovf, input logic [NB-1:0] skip);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub;
    v.sum = sum; v.cout = cout; v.ovf = ovf; v.skip = skip;
    return v;
  endfunction

  // Reference: plain wide arithmetic, signed overflow from operand/result signs.
  function automatic vec_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic cin, input logic sub);
    vec_t         v;
    logic [N-1:0] be;
    logic         ce;
    logic [N:0]   r;
    logic [N-1:0] p;
    be = sub ? ~b : b;
    ce = sub ? ~cin : cin;
    r  = {1'b0, a} + {1'b0, be} + {{N{1'b0}}, ce};
    p  = a ^ be;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub;
    v.sum  = r[N-1:0];
    v.cout = r[N];
    v.ovf  = (a[N-1] == be[N-1]) && (r[N-1] != a[N-1]);
    for (int k = 0; k < NB; k++) v.skip[k] = &p[k*BS +: BS];
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic vld);
    cur      = v;
    A        = v.a;
    B        = v.b;
    Cin      = v.cin;
    Sub      = v.sub;
    in_valid = vld;
  endtask

  task automatic wait_empty(input int lim);
    for (int i = 0; i < lim && sb.size() != 0; i++) @(posedge clk);
    #2;
    check("drain", sb.size(), 0);
  endtask

  // Monitor: samples on the falling edge what the next rising edge will do.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      sb.delete();
      first_seen = -1;
    end else if (rst === 1'b0) begin
      check("in_ready_comb", in_ready, 32'(!out_valid || out_ready));
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          if (first_seen < 0) first_seen = cyc;
          if (out_ready) begin
            e = sb.pop_front();
            check("Sum",  Sum,  e.v.sum);
            check("Cout", Cout, e.v.cout);
            check("Ovf",  Ovf,  e.v.ovf);
            check("Skip", Skip, e.v.skip);
            if (e.chk_lat) check("latency", first_seen - e.acc, LAT);
            first_seen = -1;
          end
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        e.v = cur; e.acc = cyc; e.chk_lat = lat_chk_en;
        sb.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0; out_ready = 1'b1;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000);
    tbl[1] = mk(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1111);
    tbl[2] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b0110);
    tbl[3] = mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4'b1110);
    tbl[4] = mk(16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 4'b1110);
    tbl[5] = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4'b0110);
    tbl[6] = mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 4'b0000);
    for (int i = 7; i < NV; i++)
      tbl[i] = model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_Sum",       Sum,       0);
    check("rst_Cout",      Cout,      0);
    check("rst_Ovf",       Ovf,       0);
    check("rst_Skip",      Skip,      0);
    check("rst_in_ready",  in_ready,  1);

    // Table vectors, back to back at full rate.
    lat_chk_en = 1'b1;
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive(tbl[i], 1'b1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_empty(30);

    // Random traffic with random bubbles and backpressure.
    lat_chk_en = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      drive(model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)),
            1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    wait_empty(100);

    // Backpressure: three ops, then two stalled cycles at the first result.
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      drive(mk(16'(i), 16'(i), 1'b0, 1'b0, 16'(2 * i), 1'b0, 1'b0, 4'b0000), 1'b1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 10 && out_valid !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    check("bp_out_valid", out_valid, 1);
    out_ready = 1'b0;
    drive(mk(16'h0009, 16'h0009, 1'b0, 1'b0, 16'h0012, 1'b0, 1'b0, 4'b0000), 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_in_ready",  in_ready,  0);
      check("bp_Sum_hold",  Sum,       16'h0002);
      check("bp_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; in_valid = 1'b0;
    wait_empty(20);

    // Reset with two operations in flight, then an immediate new operation.
    lat_chk_en = 1'b1;
    @(posedge clk); #1;
    drive(model(16'h0100, 16'h0100, 1'b0, 1'b0), 1'b1);
    @(posedge clk); #1;
    drive(model(16'h0200, 16'h0300, 1'b0, 1'b0), 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(mk(16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0, 4'b0000), 1'b1);
    @(negedge clk);
    check("post_rst_in_ready",  in_ready,  1);
    check("post_rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_empty(20);
    repeat (6) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
